spi_cmd_dispatch: RTL and testbench

SPI_CMD_DISPATCH -- requirements
Module: spi_cmd_dispatch

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_cmd_dispatch_if.sv | 29 ++
 rtl/spi_cmd_fifo.sv | 60 ++++++
 rtl/spi_cmd_dispatch.sv | 127 ++++++++++++
 tb/tb_spi_cmd_dispatch.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and encodings for the SPI command dispatcher and its FIFO.
package spi_pkg;

  localparam int unsigned CmdCountW = 16;

  localparam logic TGT_M1 = 1'b0;
  localparam logic TGT_M2 = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap
  } dispatch_state_e;

endpackage

// File: rtl/spi_cmd_dispatch_if.sv
// Upstream command stream plus the two downstream SPI master streams.
interface spi_cmd_dispatch_if;

  logic [31:0] s_axis_tdata;
  logic        s_axis_tdest;
  logic        s_axis_tvalid;
  logic        s_axis_tready;

  logic [31:0] m_axis_tdata_1;
  logic        m_axis_tvalid_1;
  logic        m_axis_tready_1;

  logic [31:0] m_axis_tdata_2;
  logic        m_axis_tvalid_2;
  logic        m_axis_tready_2;

  // Dispatcher side: accepts the upstream stream, sources both master streams.
  modport slave (
    input  s_axis_tdata, s_axis_tdest, s_axis_tvalid, m_axis_tready_1, m_axis_tready_2,
    output s_axis_tready, m_axis_tdata_1, m_axis_tvalid_1, m_axis_tdata_2, m_axis_tvalid_2
  );

  // Environment side: produces commands, sinks the master streams.
  modport master (
    output s_axis_tdata, s_axis_tdest, s_axis_tvalid, m_axis_tready_1, m_axis_tready_2,
    input  s_axis_tready, m_axis_tdata_1, m_axis_tvalid_1, m_axis_tdata_2, m_axis_tvalid_2
  );

endinterface

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO; the oldest entry is presented from a head register that
// becomes valid one cycle after the entry reaches the front.
module spi_cmd_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 33,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] head_q;
  logic             head_valid_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q      <= level_d;
      head_q       <= mem_q[rd_ptr_q];
      // After a pop the register still holds the old word until the next one is re-read.
      head_valid_q <= (level_q != '0) && !pop;
    end
  end

  assign head       = head_q;
  assign head_valid = head_valid_q;
  assign level      = level_q;

endmodule

// File: rtl/spi_cmd_dispatch.sv
// Buffers tagged commands and issues them one at a time, in order, to one of two SPI
// masters, with a fixed idle gap after every dispatched command.
module spi_cmd_dispatch
  import spi_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 8,
  parameter  int unsigned GAP_CYCLES = 16,
  localparam int unsigned LevelW     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  spi_cmd_dispatch_if.slave    bus,
  output logic [LevelW-1:0]    fifo_level,
  output logic [CmdCountW-1:0] cmd_count,
  output logic                 idle
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  dispatch_state_e      state_q, state_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic                 tvalid_1_q, tvalid_1_d, tvalid_2_q, tvalid_2_d;
  logic [31:0]          tdata_1_q, tdata_1_d, tdata_2_q, tdata_2_d;
  logic [CmdCountW-1:0] cmd_count_q, cmd_count_d;
  logic                 ready_en_q;
  logic                 push, pop, handshake, head_valid;
  logic [32:0]          head;

  // Upstream stays held off for the first cycle after reset release.
  assign bus.s_axis_tready = ready_en_q && (fifo_level != LevelW'(FIFO_DEPTH));
  assign push              = bus.s_axis_tvalid && bus.s_axis_tready;
  assign handshake         = (tvalid_1_q && bus.m_axis_tready_1) ||
                             (tvalid_2_q && bus.m_axis_tready_2);

  spi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .wdata      ({bus.s_axis_tdest, bus.s_axis_tdata}),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .level      (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    tvalid_1_d  = tvalid_1_q;
    tvalid_2_d  = tvalid_2_q;
    tdata_1_d   = tdata_1_q;
    tdata_2_d   = tdata_2_q;
    cmd_count_d = cmd_count_q;
    pop         = 1'b0;
    case (state_q)
      StIdle: begin
        if (head_valid) begin
          if (head[32] == TGT_M2) begin
            tvalid_2_d = 1'b1;
            tdata_2_d  = {24'h0, head[7:0]};
          end else begin
            tvalid_1_d = 1'b1;
            tdata_1_d  = head[31:0];
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (handshake) begin
          pop         = 1'b1;
          cmd_count_d = cmd_count_q + 1'b1;
          tvalid_1_d  = 1'b0;
          tvalid_2_d  = 1'b0;
          tdata_1_d   = '0;
          tdata_2_d   = '0;
          if (GAP_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            gap_d   = GapW'(GAP_CYCLES - 1);
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      gap_q       <= '0;
      tvalid_1_q  <= 1'b0;
      tvalid_2_q  <= 1'b0;
      tdata_1_q   <= '0;
      tdata_2_q   <= '0;
      cmd_count_q <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      tvalid_1_q  <= tvalid_1_d;
      tvalid_2_q  <= tvalid_2_d;
      tdata_1_q   <= tdata_1_d;
      tdata_2_q   <= tdata_2_d;
      cmd_count_q <= cmd_count_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign bus.m_axis_tvalid_1 = tvalid_1_q;
  assign bus.m_axis_tdata_1  = tdata_1_q;
  assign bus.m_axis_tvalid_2 = tvalid_2_q;
  assign bus.m_axis_tdata_2  = tdata_2_q;
  assign cmd_count           = cmd_count_q;
  assign idle                = (fifo_level == '0) && (state_q == StIdle);

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// Directed bench for spi_cmd_dispatch: latency, routing, back-pressure, gap spacing,
// reset discard and counter wrap.
module tb_spi_cmd_dispatch;

  localparam int unsigned Depth = 8;
  localparam int unsigned Gap   = 16;

  logic        clk    = 1'b0;
  logic        resetn = 1'b1;
  logic [3:0]  fifo_level;
  logic [15:0] cmd_count;
  logic        idle;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  spi_cmd_dispatch_if bus ();

  spi_cmd_dispatch #(
    .FIFO_DEPTH (Depth),
    .GAP_CYCLES (Gap)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .fifo_level (fifo_level),
    .cmd_count  (cmd_count),
    .idle       (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed downstream traffic; edge numbers refer to cyc.
  int          hs_cyc[$];
  logic [31:0] hs_data[$];
  logic        hs_dest[$];
  int          rise_cyc[$];
  logic        prev_tv = 1'b0;

  always @(negedge clk) begin
    #2;
    if (bus.m_axis_tvalid_1 && bus.m_axis_tready_1) begin
      hs_cyc.push_back(cyc + 1); hs_data.push_back(bus.m_axis_tdata_1); hs_dest.push_back(1'b0);
    end else if (bus.m_axis_tvalid_2 && bus.m_axis_tready_2) begin
      hs_cyc.push_back(cyc + 1); hs_data.push_back(bus.m_axis_tdata_2); hs_dest.push_back(1'b1);
    end
    if ((bus.m_axis_tvalid_1 || bus.m_axis_tvalid_2) && !prev_tv) rise_cyc.push_back(cyc);
    prev_tv = bus.m_axis_tvalid_1 || bus.m_axis_tvalid_2;
  end

  task automatic clear_obs();
    hs_cyc.delete(); hs_data.delete(); hs_dest.delete(); rise_cyc.delete();
  endtask

  task automatic push(input logic dest, input logic [31:0] data, output int acc);
    int n = 0;
    @(negedge clk);
    bus.s_axis_tdest = dest; bus.s_axis_tdata = data; bus.s_axis_tvalid = 1'b1;
    while (bus.s_axis_tready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (bus.s_axis_tready !== 1'b1) begin
      failures++; $display("FAIL push_ready_timeout: tready=%b want 1", bus.s_axis_tready);
    end
    @(posedge clk); #1;
    acc = cyc;
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (idle !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (idle !== 1'b1) begin failures++; $display("FAIL %s_idle: idle=%b want 1", tag, idle); end
  endtask

  task automatic wait_hs(input int want, input string tag);
    int n = 0;
    while (hs_cyc.size() < want && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (hs_cyc.size() != want) begin
      failures++; $display("FAIL %s_hs_count: got %0d want %0d", tag, hs_cyc.size(), want);
    end
  endtask

  task automatic test_reset();
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tdest = 1'b0;
    bus.m_axis_tready_1 = 1'b0; bus.m_axis_tready_2 = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks += 8;
    if (bus.s_axis_tready !== 1'b0) begin failures++; $display("FAIL rst_tready: got %b want 0", bus.s_axis_tready); end
    if (bus.m_axis_tvalid_1 !== 1'b0) begin failures++; $display("FAIL rst_tvalid_1: got %b want 0", bus.m_axis_tvalid_1); end
    if (bus.m_axis_tvalid_2 !== 1'b0) begin failures++; $display("FAIL rst_tvalid_2: got %b want 0", bus.m_axis_tvalid_2); end
    if (bus.m_axis_tdata_1 !== 32'h0) begin failures++; $display("FAIL rst_tdata_1: got %h want 0", bus.m_axis_tdata_1); end
    if (bus.m_axis_tdata_2 !== 32'h0) begin failures++; $display("FAIL rst_tdata_2: got %h want 0", bus.m_axis_tdata_2); end
    if (fifo_level !== 4'd0) begin failures++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    if (cmd_count !== 16'h0) begin failures++; $display("FAIL rst_count: got %h want 0", cmd_count); end
    if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle: got %b want 1", idle); end
    resetn = 1'b1;
    #1;
    checks++;
    if (bus.s_axis_tready !== 1'b0) begin failures++; $display("FAIL rel_tready_early: got %b want 0", bus.s_axis_tready); end
    @(negedge clk);
    checks++;
    if (bus.s_axis_tready !== 1'b1) begin failures++; $display("FAIL rel_tready: got %b want 1", bus.s_axis_tready); end
  endtask

  task automatic test_single();
    int n;
    bus.m_axis_tready_1 = 1'b1; bus.m_axis_tready_2 = 1'b1;
    push(1'b0, 32'hDEADBEEF, n);
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd1) begin failures++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    @(negedge clk);
    checks++;
    if (bus.m_axis_tvalid_1 !== 1'b0) begin failures++; $display("FAIL single_early: tvalid_1=%b want 0", bus.m_axis_tvalid_1); end
    @(negedge clk);
    checks += 3;
    if (bus.m_axis_tvalid_1 !== 1'b1) begin failures++; $display("FAIL single_tvalid_1: got %b want 1", bus.m_axis_tvalid_1); end
    if (bus.m_axis_tdata_1 !== 32'hDEADBEEF) begin failures++; $display("FAIL single_tdata_1: got %h want deadbeef", bus.m_axis_tdata_1); end
    if (bus.m_axis_tvalid_2 !== 1'b0) begin failures++; $display("FAIL single_tvalid_2: got %b want 0", bus.m_axis_tvalid_2); end
    @(negedge clk);
    checks += 3;
    if (bus.m_axis_tvalid_1 !== 1'b0) begin failures++; $display("FAIL single_drop: tvalid_1=%b want 0", bus.m_axis_tvalid_1); end
    if (bus.m_axis_tdata_1 !== 32'h0) begin failures++; $display("FAIL single_tdata_clr: got %h want 0", bus.m_axis_tdata_1); end
    if (cmd_count !== 16'd1) begin failures++; $display("FAIL single_count: got %0d want 1", cmd_count); end
    wait_idle("single");
  endtask

  task automatic test_target2();
    int n;
    push(1'b1, 32'h123456A5, n);
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.m_axis_tvalid_2 !== 1'b1) begin failures++; $display("FAIL t2_tvalid_2: got %b want 1", bus.m_axis_tvalid_2); end
    if (bus.m_axis_tdata_2 !== 32'h000000A5) begin failures++; $display("FAIL t2_tdata_2: got %h want 000000a5", bus.m_axis_tdata_2); end
    if (bus.m_axis_tvalid_1 !== 1'b0) begin failures++; $display("FAIL t2_tvalid_1: got %b want 0", bus.m_axis_tvalid_1); end
    if (bus.m_axis_tdata_1 !== 32'h0) begin failures++; $display("FAIL t2_tdata_1: got %h want 0", bus.m_axis_tdata_1); end
    @(negedge clk);
    checks++;
    if (cmd_count !== 16'd2) begin failures++; $display("FAIL t2_count: got %0d want 2", cmd_count); end
    wait_idle("t2");
  endtask

  task automatic test_full();
    int n;
    clear_obs();
    bus.m_axis_tready_1 = 1'b0;
    for (int i = 0; i < 8; i++) push(1'b0, 32'hF000_0000 + i, n);
    @(negedge clk);
    checks += 4;
    if (bus.s_axis_tready !== 1'b0) begin failures++; $display("FAIL full_tready: got %b want 0", bus.s_axis_tready); end
    if (fifo_level !== 4'd8) begin failures++; $display("FAIL full_level: got %0d want 8", fifo_level); end
    if (bus.m_axis_tvalid_1 !== 1'b1) begin failures++; $display("FAIL full_stall_valid: got %b want 1", bus.m_axis_tvalid_1); end
    if (bus.m_axis_tdata_1 !== 32'hF0000000) begin failures++; $display("FAIL full_stall_data: got %h want f0000000", bus.m_axis_tdata_1); end
    bus.s_axis_tdest = 1'b0; bus.s_axis_tdata = 32'hF000_0008; bus.s_axis_tvalid = 1'b1;
    repeat (4) @(negedge clk);
    checks += 2;
    if (fifo_level !== 4'd8) begin failures++; $display("FAIL full_hold_level: got %0d want 8", fifo_level); end
    if (bus.s_axis_tready !== 1'b0) begin failures++; $display("FAIL full_hold_tready: got %b want 0", bus.s_axis_tready); end
    bus.m_axis_tready_1 = 1'b1;
    @(negedge clk);
    checks += 3;
    if (fifo_level !== 4'd7) begin failures++; $display("FAIL full_pop_level: got %0d want 7", fifo_level); end
    if (bus.s_axis_tready !== 1'b1) begin failures++; $display("FAIL full_pop_tready: got %b want 1", bus.s_axis_tready); end
    if (cmd_count !== 16'd3) begin failures++; $display("FAIL full_pop_count: got %0d want 3", cmd_count); end
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    checks++;
    if (fifo_level !== 4'd8) begin failures++; $display("FAIL full_ninth_level: got %0d want 8", fifo_level); end
    wait_hs(9, "full");
    for (int i = 0; i < 9; i++) begin
      if (i < hs_data.size()) begin
        checks++;
        if (hs_data[i] !== 32'hF000_0000 + i) begin
          failures++; $display("FAIL full_order[%0d]: got %h want %h", i, hs_data[i], 32'hF000_0000 + i);
        end
      end
    end
    wait_idle("full");
  endtask

  task automatic test_gap();
    int a, b, c;
    clear_obs();
    bus.m_axis_tready_1 = 1'b1; bus.m_axis_tready_2 = 1'b1;
    push(1'b0, 32'h11111111, a);
    push(1'b1, 32'h222222C3, b);
    push(1'b0, 32'h33333333, c);
    wait_hs(3, "gap");
    checks++;
    if (rise_cyc.size() != 3) begin
      failures++; $display("FAIL gap_rises: got %0d want 3", rise_cyc.size());
    end else if (hs_cyc.size() == 3) begin
      checks += 10;
      if (rise_cyc[0] != a + 2) begin failures++; $display("FAIL gap_latency: got %0d want %0d", rise_cyc[0] - a, 2); end
      if (hs_cyc[0] != a + 3) begin failures++; $display("FAIL gap_first_hs: got %0d want %0d", hs_cyc[0] - a, 3); end
      if (rise_cyc[1] - hs_cyc[0] != 17) begin failures++; $display("FAIL gap_space_1: got %0d want 17", rise_cyc[1] - hs_cyc[0]); end
      if (rise_cyc[2] - hs_cyc[1] != 17) begin failures++; $display("FAIL gap_space_2: got %0d want 17", rise_cyc[2] - hs_cyc[1]); end
      if (hs_data[0] !== 32'h11111111) begin failures++; $display("FAIL gap_data_0: got %h want 11111111", hs_data[0]); end
      if (hs_data[1] !== 32'h000000C3) begin failures++; $display("FAIL gap_data_1: got %h want 000000c3", hs_data[1]); end
      if (hs_data[2] !== 32'h33333333) begin failures++; $display("FAIL gap_data_2: got %h want 33333333", hs_data[2]); end
      if (hs_dest[0] !== 1'b0) begin failures++; $display("FAIL gap_dest_0: got %b want 0", hs_dest[0]); end
      if (hs_dest[1] !== 1'b1) begin failures++; $display("FAIL gap_dest_1: got %b want 1", hs_dest[1]); end
      if (hs_dest[2] !== 1'b0) begin failures++; $display("FAIL gap_dest_2: got %b want 0", hs_dest[2]); end
    end
    wait_idle("gap");
  endtask

  task automatic test_reset_mid();
    int n;
    bus.m_axis_tready_1 = 1'b0;
    for (int i = 0; i < 6; i++) push(1'b0, 32'hA0 + i, n);
    @(negedge clk);
    checks += 2;
    if (bus.m_axis_tvalid_1 !== 1'b1) begin failures++; $display("FAIL mid_in_issue: got %b want 1", bus.m_axis_tvalid_1); end
    if (fifo_level !== 4'd6) begin failures++; $display("FAIL mid_level: got %0d want 6", fifo_level); end
    resetn = 1'b0;
    #1;
    checks += 5;
    if (fifo_level !== 4'd0) begin failures++; $display("FAIL mid_rst_level: got %0d want 0", fifo_level); end
    if (bus.m_axis_tvalid_1 !== 1'b0) begin failures++; $display("FAIL mid_rst_tvalid_1: got %b want 0", bus.m_axis_tvalid_1); end
    if (bus.m_axis_tdata_1 !== 32'h0) begin failures++; $display("FAIL mid_rst_tdata_1: got %h want 0", bus.m_axis_tdata_1); end
    if (bus.s_axis_tready !== 1'b0) begin failures++; $display("FAIL mid_rst_tready: got %b want 0", bus.s_axis_tready); end
    if (cmd_count !== 16'h0) begin failures++; $display("FAIL mid_rst_count: got %h want 0", cmd_count); end
    @(negedge clk);
    resetn = 1'b1;
    bus.m_axis_tready_1 = 1'b1;
    clear_obs();
    repeat (30) @(negedge clk);
    checks += 3;
    if (rise_cyc.size() != 0) begin failures++; $display("FAIL mid_ghost_valid: got %0d want 0", rise_cyc.size()); end
    if (fifo_level !== 4'd0) begin failures++; $display("FAIL mid_post_level: got %0d want 0", fifo_level); end
    if (idle !== 1'b1) begin failures++; $display("FAIL mid_post_idle: got %b want 1", idle); end
    push(1'b1, 32'h55AA55AA, n);
    repeat (3) @(negedge clk);
    checks += 2;
    if (bus.m_axis_tvalid_2 !== 1'b1) begin failures++; $display("FAIL mid_new_valid: got %b want 1", bus.m_axis_tvalid_2); end
    if (bus.m_axis_tdata_2 !== 32'h000000AA) begin failures++; $display("FAIL mid_new_data: got %h want 000000aa", bus.m_axis_tdata_2); end
    @(negedge clk);
    checks++;
    if (cmd_count !== 16'd1) begin failures++; $display("FAIL mid_new_count: got %0d want 1", cmd_count); end
    wait_idle("mid");
  endtask

  task automatic test_wrap();
    int n;
    @(negedge clk);
    force dut.cmd_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.cmd_count_q;
    @(negedge clk);
    checks++;
    if (cmd_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preset: got %h want ffff", cmd_count); end
    push(1'b0, 32'h0BADF00D, n);
    repeat (4) @(negedge clk);
    checks++;
    if (cmd_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero: got %h want 0000", cmd_count); end
    wait_idle("wrap");
    push(1'b1, 32'h00000042, n);
    repeat (4) @(negedge clk);
    checks++;
    if (cmd_count !== 16'h0001) begin failures++; $display("FAIL wrap_next: got %h want 0001", cmd_count); end
    wait_idle("wrap2");
  endtask

  initial begin
    test_reset();
    test_single();
    test_target2();
    test_full();
    test_gap();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
